// File: rtl/lb_mode_core_select.sv
// Core-selection engine: per interface request, picks a core by RR / least-loaded / flow-hash,
// pops that core's descriptor and hands the {core,tag} back to the requesting interface.
module lb_mode_core_select #(
  parameter int IF_COUNT      = 3,
  parameter int CORE_COUNT    = 8,
  parameter int SLOT_COUNT    = 32,
  parameter int HASH_WIDTH    = 32,
  parameter int SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
  parameter int CORE_ID_WIDTH = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1,
  parameter int IF_WIDTH      = (IF_COUNT > 1) ? $clog2(IF_COUNT) : 1,
  parameter int TAG_WIDTH     = (SLOT_WIDTH > 5) ? SLOT_WIDTH : 5,
  parameter int ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IF_COUNT-1:0]              req_valid,
  input  logic [IF_COUNT*HASH_WIDTH-1:0]   req_hash,
  output logic [IF_COUNT-1:0]              req_ready,
  output logic [IF_COUNT-1:0]              resp_valid,
  output logic [ID_TAG_WIDTH-1:0]          resp_desc,
  input  logic [IF_COUNT-1:0]              resp_ready,
  output logic [CORE_COUNT-1:0]            enabled_cores,
  output logic [CORE_COUNT-1:0]            slots_flush,
  input  logic [CORE_COUNT*SLOT_WIDTH-1:0] slot_counts,
  input  logic [CORE_COUNT-1:0]            slot_valids,
  input  logic [CORE_COUNT-1:0]            slot_busys,
  output logic [CORE_ID_WIDTH-1:0]         selected_core,
  output logic                             desc_pop,
  input  logic [ID_TAG_WIDTH-1:0]          desc_data,
  input  logic [28:0]                      host_cmd,
  input  logic [31:0]                      host_cmd_wr_data,
  input  logic                             host_cmd_wr_en,
  output logic [31:0]                      host_cmd_rd_data
);

  // state  | meaning
  // S_IDLE | waiting for a request with an eligible candidate core
  // S_SEL  | core chosen; pop its descriptor if it still has one
  // S_RESP | grant presented to the interface until it is consumed
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEL = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  state_t                   r_state, w_next_state;
  logic [1:0]               r_mode;
  logic [CORE_COUNT-1:0]    r_enabled, r_flush;
  logic [CORE_ID_WIDTH-1:0] r_last_core, r_sel;
  logic [IF_WIDTH-1:0]      r_if_ptr, r_if;
  logic [ID_TAG_WIDTH-1:0]  r_desc;
  logic                     r_first;
  logic [31:0]              r_grant_cnt, r_stall_cnt, r_rd_data;

  logic [CORE_COUNT-1:0]    w_elig;
  logic                     w_if_found;
  logic [IF_WIDTH-1:0]      w_if, w_if_idx;
  logic [HASH_WIDTH-1:0]    w_hash;
  logic [CORE_ID_WIDTH-1:0] w_hash_core;
  logic                     w_rr_found;
  logic [CORE_ID_WIDTH-1:0] w_rr_core, w_rr_idx;
  logic                     w_least_found;
  logic [CORE_ID_WIDTH-1:0] w_least_core;
  logic [SLOT_WIDTH-1:0]    w_least_cnt;
  logic                     w_cand_ok;
  logic [CORE_ID_WIDTH-1:0] w_cand;
  logic                     w_decide, w_stall, w_pop_ok, w_done, w_clr;
  logic [3:0]               w_addr;
  logic [31:0]              w_rd_mux;
  logic                     w_unused;

  assign w_elig   = r_enabled & slot_valids & ~slot_busys & ~r_flush;
  assign w_addr   = host_cmd[3:0];
  assign w_unused = ^{host_cmd[28:4], host_cmd_wr_data};

  // Interface arbitration starts at the one after the last served interface.
  always_comb begin
    w_if_found = 1'b0;
    w_if       = '0;
    w_if_idx   = '0;
    for (int i = 0; i < IF_COUNT; i++) begin
      w_if_idx = IF_WIDTH'((int'(r_if_ptr) + i) % IF_COUNT);
      if (!w_if_found && req_valid[w_if_idx]) begin
        w_if_found = 1'b1;
        w_if       = w_if_idx;
      end
    end
  end

  always_comb begin
    w_hash = '0;
    for (int i = 0; i < IF_COUNT; i++) begin
      if (IF_WIDTH'(i) == w_if) w_hash = req_hash[i*HASH_WIDTH +: HASH_WIDTH];
    end
    w_hash_core = CORE_ID_WIDTH'(w_hash % HASH_WIDTH'(CORE_COUNT));
  end

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_core  = '0;
    w_rr_idx   = '0;
    for (int i = 1; i <= CORE_COUNT; i++) begin
      w_rr_idx = CORE_ID_WIDTH'((int'(r_last_core) + i) % CORE_COUNT);
      if (!w_rr_found && w_elig[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_core  = w_rr_idx;
      end
    end
  end

  // Strict '>' keeps the lowest index on equal free-slot counts.
  always_comb begin
    w_least_found = 1'b0;
    w_least_core  = '0;
    w_least_cnt   = '0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      if (w_elig[c] && (!w_least_found || slot_counts[c*SLOT_WIDTH +: SLOT_WIDTH] > w_least_cnt)) begin
        w_least_found = 1'b1;
        w_least_core  = CORE_ID_WIDTH'(c);
        w_least_cnt   = slot_counts[c*SLOT_WIDTH +: SLOT_WIDTH];
      end
    end
  end

  // Hash mode keeps flow affinity: an ineligible hashed core stalls rather than falls back.
  always_comb begin
    w_cand    = w_rr_core;
    w_cand_ok = w_rr_found;
    case (r_mode)
      2'd1: begin
        w_cand    = w_least_core;
        w_cand_ok = w_least_found;
      end
      2'd2: begin
        w_cand    = w_hash_core;
        w_cand_ok = w_elig[w_hash_core];
      end
      default: ;
    endcase
  end

  assign w_decide = (r_state == S_IDLE) && w_if_found && w_cand_ok;
  assign w_stall  = (r_state == S_IDLE) && w_if_found && !w_cand_ok;
  assign w_pop_ok = slot_valids[r_sel];
  assign w_done   = (r_state == S_RESP) && resp_ready[r_if];
  assign w_clr    = host_cmd_wr_en && (w_addr == 4'd5);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_decide) w_next_state = S_SEL;
      S_SEL:   w_next_state = w_pop_ok ? S_RESP : S_IDLE;
      S_RESP:  if (resp_ready[r_if]) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    desc_pop   = (r_state == S_SEL) && w_pop_ok;
    resp_valid = '0;
    req_ready  = '0;
    if (r_state == S_RESP) begin
      resp_valid[r_if] = 1'b1;
      req_ready[r_if]  = r_first;
    end
  end

  always_comb begin
    case (w_addr)
      4'd0:    w_rd_mux = {30'd0, r_mode};
      4'd1:    w_rd_mux = 32'(r_enabled);
      4'd2:    w_rd_mux = 32'(r_flush);
      4'd3:    w_rd_mux = r_grant_cnt;
      4'd4:    w_rd_mux = r_stall_cnt;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= '0;
      r_enabled   <= '0;
      r_flush     <= '0;
      r_last_core <= CORE_ID_WIDTH'(CORE_COUNT - 1);
      r_sel       <= '0;
      r_if_ptr    <= '0;
      r_if        <= '0;
      r_desc      <= '0;
      r_first     <= 1'b0;
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
      r_rd_data   <= '0;
    end else begin
      if (host_cmd_wr_en) begin
        case (w_addr)
          4'd0:    r_mode    <= host_cmd_wr_data[1:0];
          4'd1:    r_enabled <= host_cmd_wr_data[CORE_COUNT-1:0];
          4'd2:    r_flush   <= host_cmd_wr_data[CORE_COUNT-1:0];
          default: ;
        endcase
      end
      if (w_clr) begin
        r_grant_cnt <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (w_done) r_grant_cnt <= r_grant_cnt + 32'd1;
        if (w_stall && r_stall_cnt != STALL_MAX) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_decide) begin
        r_sel <= w_cand;
        r_if  <= w_if;
      end
      if (r_state == S_SEL && w_pop_ok) r_desc <= desc_data;
      r_first <= (r_state == S_SEL) && w_pop_ok;
      if (w_done) begin
        r_last_core <= r_sel;
        r_if_ptr    <= (r_if == IF_WIDTH'(IF_COUNT - 1)) ? '0 : r_if + IF_WIDTH'(1);
      end
      r_rd_data <= w_rd_mux;
    end
  end

  assign resp_desc        = r_desc;
  assign selected_core    = r_sel;
  assign enabled_cores    = r_enabled;
  assign slots_flush      = r_flush;
  assign host_cmd_rd_data = r_rd_data;

endmodule

// File: tb/tb_lb_mode_core_select.sv
// Bench for lb_mode_core_select: directed scenarios plus randomized grants checked against
// a transaction-level model of the selection policies.
module tb_lb_mode_core_select;
  localparam int IFC = 3, CC = 8, HW = 32, SW = 6, CIDW = 3, TW = 6, IDTW = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [IFC-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [IFC*HW-1:0] req_hash;
  logic [IDTW-1:0]   resp_desc, desc_data;
  logic [CC-1:0]     enabled_cores, slots_flush, slot_valids, slot_busys;
  logic [CC*SW-1:0]  slot_counts;
  logic [CIDW-1:0]   selected_core;
  logic              desc_pop;
  logic [28:0]       host_cmd;
  logic [31:0]       wr_data, rd_data;
  logic              wr_en;

  int vectors = 0, miscompares = 0;
  int m_last_core, m_if_ptr, m_grants;

  lb_mode_core_select dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_hash(req_hash), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_desc(resp_desc), .resp_ready(resp_ready),
    .enabled_cores(enabled_cores), .slots_flush(slots_flush),
    .slot_counts(slot_counts), .slot_valids(slot_valids), .slot_busys(slot_busys),
    .selected_core(selected_core), .desc_pop(desc_pop), .desc_data(desc_data),
    .host_cmd(host_cmd), .host_cmd_wr_data(wr_data), .host_cmd_wr_en(wr_en),
    .host_cmd_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] tag_of(input int c);
    return TW'(c * 7 + 3);
  endfunction

  // Stand-in for lb_controller's combinational descriptor readback.
  assign desc_data = {selected_core, tag_of(int'(selected_core))};

  function automatic int model_if(input logic [IFC-1:0] req, input int ptr);
    for (int k = 0; k < IFC; k++) if (req[(ptr + k) % IFC]) return (ptr + k) % IFC;
    return -1;
  endfunction

  function automatic int model_core(input int mode, input logic [CC-1:0] elig,
                                    input logic [CC*SW-1:0] cnt, input logic [HW-1:0] hash,
                                    input int last);
    int best;
    int c;
    best = -1;
    if (mode == 1) begin
      for (int k = 0; k < CC; k++)
        if (elig[k] && (best < 0 || cnt[k*SW +: SW] > cnt[best*SW +: SW])) best = k;
    end else if (mode == 2) begin
      c = int'(hash % HW'(CC));
      if (elig[c]) best = c;
    end else begin
      for (int k = 1; k <= CC; k++) begin
        c = (last + k) % CC;
        if (best < 0 && elig[c]) best = c;
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int addr, input logic [31:0] data);
    host_cmd = 29'(addr);
    wr_data  = data;
    wr_en    = 1'b1;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic host_read(input int addr, output logic [31:0] data);
    host_cmd = 29'(addr);
    wr_en    = 1'b0;
    tick();
    data = rd_data;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
    m_last_core = CC - 1;
    m_if_ptr    = 0;
    m_grants    = 0;
  endtask

  // Waits for a grant, checks it, optionally stalls the consumer, then consumes it.
  task automatic run_grant(input int exp_if, input int exp_core, input int hold, output int lat);
    logic [IFC-1:0]  exp_mask;
    logic [IDTW-1:0] exp_desc;
    int pops;
    bit got;
    exp_mask = '0;
    exp_mask[exp_if] = 1'b1;
    exp_desc = {CIDW'(exp_core), tag_of(exp_core)};
    pops = 0;
    got  = 1'b0;
    lat  = 0;
    while (!got && lat < 16) begin
      tick();
      lat++;
      if (desc_pop === 1'b1) pops++;
      if (resp_valid !== '0) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL grant_wait: no resp_valid after %0d cycles, required IF%0d core %0d", lat, exp_if, exp_core);
      return;
    end
    vectors++;
    if (resp_valid !== exp_mask) begin
      miscompares++;
      $display("FAIL resp_valid: got %b required %b", resp_valid, exp_mask);
    end
    vectors++;
    if (req_ready !== exp_mask) begin
      miscompares++;
      $display("FAIL req_ready_pulse: got %b required %b", req_ready, exp_mask);
    end
    vectors++;
    if (resp_desc !== exp_desc) begin
      miscompares++;
      $display("FAIL resp_desc: got core %0d tag %0d required core %0d tag %0d",
               resp_desc[IDTW-1 -: CIDW], resp_desc[TW-1:0], exp_core, tag_of(exp_core));
    end
    vectors++;
    if (pops != 1) begin
      miscompares++;
      $display("FAIL desc_pop_count: got %0d required 1", pops);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      vectors++;
      if ({resp_valid, resp_desc, req_ready} !== {exp_mask, exp_desc, 3'b000}) begin
        miscompares++;
        $display("FAIL hold_stable cycle %0d: valid %b desc %h ready %b required valid %b desc %h ready 000",
                 h, resp_valid, resp_desc, req_ready, exp_mask, exp_desc);
      end
    end
    resp_ready = exp_mask;
    tick();
    resp_ready = '0;
    vectors++;
    if (resp_valid !== '0) begin
      miscompares++;
      $display("FAIL release: resp_valid got %b required 000", resp_valid);
    end
    m_last_core = exp_core;
    m_if_ptr    = (exp_if + 1) % IFC;
    m_grants++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    vectors++;
    if ({req_ready, resp_valid, resp_desc, enabled_cores, slots_flush, selected_core, desc_pop, rd_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rr %b rv %b desc %h en %h fl %h sel %0d pop %b rd %h required all 0",
               req_ready, resp_valid, resp_desc, enabled_cores, slots_flush, selected_core, desc_pop, rd_data);
    end
    for (int a = 0; a < 8; a++) begin
      host_read(a, d);
      vectors++;
      if (d !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h required 0", a, d);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    host_write(0, 32'hFFFF_FFFE);
    host_read(0, d);
    vectors++;
    if (d !== 32'd2) begin miscompares++; $display("FAIL reg_mode: got %h required 2", d); end
    host_write(1, 32'h1234_56A5);
    host_read(1, d);
    vectors++;
    if (d !== 32'hA5 || enabled_cores !== 8'hA5) begin
      miscompares++;
      $display("FAIL reg_enable: got rd %h port %h required a5", d, enabled_cores);
    end
    host_write(2, 32'h0000_003C);
    host_read(2, d);
    vectors++;
    if (d !== 32'h3C || slots_flush !== 8'h3C) begin
      miscompares++;
      $display("FAIL reg_flush: got rd %h port %h required 3c", d, slots_flush);
    end
    host_write(3, 32'hDEAD_BEEF);
    host_read(3, d);
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL reg_grant_ro: got %h required 0", d); end
    host_read(9, d);
    vectors++;
    if (d !== 32'd0) begin miscompares++; $display("FAIL reg_unmapped: got %h required 0", d); end
    host_write(0, 32'd0);
    host_write(1, 32'd0);
    host_write(2, 32'd0);
  endtask

  task automatic test_rr();
    int exp, lat;
    logic [31:0] d;
    slot_valids = 8'hFF;
    slot_busys  = 8'h00;
    host_write(0, 32'd0);
    host_write(1, 32'hFF);
    host_write(5, 32'd0);
    m_grants = 0;
    req_valid = 3'b001;
    for (int n = 0; n < 9; n++) begin
      exp = model_core(0, 8'hFF, slot_counts, req_hash[HW-1:0], m_last_core);
      run_grant(0, exp, 0, lat);
      vectors++;
      if (lat != 2) begin miscompares++; $display("FAIL rr_latency grant %0d: got %0d required 2", n, lat); end
    end
    req_valid = '0;
    host_read(3, d);
    vectors++;
    if (d !== 32'(m_grants)) begin miscompares++; $display("FAIL grant_count: got %0d required %0d", d, m_grants); end
  endtask

  task automatic test_least();
    int lat;
    slot_counts = '0;
    slot_counts[0*SW +: SW] = 6'd3;
    slot_counts[1*SW +: SW] = 6'd9;
    slot_counts[2*SW +: SW] = 6'd9;
    slot_counts[3*SW +: SW] = 6'd1;
    for (int c = 4; c < CC; c++) slot_counts[c*SW +: SW] = 6'd20;
    host_write(0, 32'd1);
    host_write(1, 32'h0F);
    req_valid = 3'b001;
    run_grant(0, 1, 0, lat);
    req_valid = '0;
  endtask

  task automatic test_hash();
    int lat;
    host_write(0, 32'd2);
    host_write(1, 32'hDF);
    req_hash[HW-1:0] = 32'hABCD_120D;
    host_write(5, 32'd0);
    host_cmd  = 29'd4;
    req_valid = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (rd_data !== 32'(k - 1) || resp_valid !== '0) begin
        miscompares++;
        $display("FAIL stall_count cycle %0d: got %0d valid %b required %0d valid 000", k, rd_data, resp_valid, k - 1);
      end
    end
    req_valid = '0;
    tick();
    vectors++;
    if (rd_data !== 32'd5) begin miscompares++; $display("FAIL stall_total: got %0d required 5", rd_data); end
    host_write(1, 32'hFF);
    req_valid = 3'b001;
    run_grant(0, 5, 0, lat);
    req_valid = '0;
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL hash_latency: got %0d required 2", lat); end
  endtask

  task automatic test_multi_if();
    int ei, ec, lat;
    do_reset();
    slot_valids = 8'hFF;
    slot_busys  = 8'h00;
    host_write(1, 32'hFF);
    req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      ei = model_if(req_valid, m_if_ptr);
      ec = model_core(0, 8'hFF, slot_counts, req_hash[ei*HW +: HW], m_last_core);
      run_grant(ei, ec, (n == 0) ? 5 : 0, lat);
    end
    req_valid = '0;
  endtask

  task automatic test_sel_drop();
    int exp, nxt, lat;
    slot_valids = 8'hFF;
    exp = model_core(0, 8'hFF, slot_counts, req_hash[HW-1:0], m_last_core);
    req_valid = 3'b001;
    tick();
    vectors++;
    if (selected_core !== CIDW'(exp) || desc_pop !== 1'b1) begin
      miscompares++;
      $display("FAIL sel_entry: sel %0d pop %b required sel %0d pop 1", selected_core, desc_pop, exp);
    end
    slot_valids[exp] = 1'b0;
    #1;
    vectors++;
    if (desc_pop !== 1'b0) begin miscompares++; $display("FAIL sel_drop_pop: got %b required 0", desc_pop); end
    nxt = model_core(0, slot_valids, slot_counts, req_hash[HW-1:0], m_last_core);
    run_grant(0, nxt, 0, lat);
    req_valid   = '0;
    slot_valids = 8'hFF;
  endtask

  task automatic test_random();
    logic [IFC-1:0]   rq;
    logic [CC-1:0]    en, sv, sb, fl, el;
    logic [CC*SW-1:0] cnt;
    logic [IFC*HW-1:0] hs;
    int mode, ei, ec, lat;
    for (int it = 0; it < 24; it++) begin
      ei = -1;
      ec = -1;
      for (int t = 0; t < 50 && ec < 0; t++) begin
        rq   = IFC'($urandom_range(1, 7));
        mode = $urandom_range(0, 3);
        en   = CC'($urandom);
        sv   = CC'($urandom | $urandom);
        sb   = CC'($urandom & $urandom & $urandom);
        fl   = CC'($urandom & $urandom);
        for (int c = 0; c < CC; c++) cnt[c*SW +: SW] = SW'($urandom_range(0, 32));
        for (int i = 0; i < IFC; i++) hs[i*HW +: HW] = $urandom;
        el = en & sv & ~sb & ~fl;
        ei = model_if(rq, m_if_ptr);
        ec = model_core(mode, el, cnt, hs[ei*HW +: HW], m_last_core);
      end
      if (ec < 0) continue;
      slot_valids = sv;
      slot_busys  = sb;
      slot_counts = cnt;
      req_hash    = hs;
      host_write(0, 32'(mode));
      host_write(1, 32'(en));
      host_write(2, 32'(fl));
      req_valid = rq;
      run_grant(ei, ec, $urandom_range(0, 2), lat);
      req_valid = '0;
      vectors++;
      if (lat != 2) begin miscompares++; $display("FAIL rand_latency iter %0d: got %0d required 2", it, lat); end
    end
    host_write(2, 32'd0);
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] d;
    int pops;
    slot_valids = 8'hFF;
    slot_busys  = 8'h00;
    host_write(0, 32'd0);
    host_write(1, 32'hFF);
    req_valid = 3'b001;
    tick();
    tick();
    vectors++;
    if (resp_valid !== 3'b001) begin miscompares++; $display("FAIL pre_reset_resp: got %b required 001", resp_valid); end
    rst = 1'b1;
    tick();
    vectors++;
    if ({req_ready, resp_valid, resp_desc, enabled_cores, slots_flush, selected_core, desc_pop, rd_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_in_resp: rr %b rv %b desc %h en %h fl %h sel %0d pop %b rd %h required all 0",
               req_ready, resp_valid, resp_desc, enabled_cores, slots_flush, selected_core, desc_pop, rd_data);
    end
    rst = 1'b0;
    req_valid = '0;
    m_last_core = CC - 1;
    m_if_ptr    = 0;
    m_grants    = 0;
    pops = 0;
    for (int k = 0; k < 4; k++) begin
      host_read(k, d);
      if (desc_pop === 1'b1) pops++;
      vectors++;
      if (d !== 32'd0) begin miscompares++; $display("FAIL post_reset_reg%0d: got %h required 0", k, d); end
    end
    host_read(4, d);
    vectors++;
    if (d !== 32'd0 || pops != 0) begin
      miscompares++;
      $display("FAIL post_reset_stall: got %0d pops %0d required 0 pops 0", d, pops);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_hash = '0; resp_ready = '0;
    slot_counts = '0; slot_valids = '0; slot_busys = '0;
    host_cmd = '0; wr_data = '0; wr_en = 1'b0;
    test_reset();
    test_regs();
    test_rr();
    test_least();
    test_hash();
    test_multi_if();
    test_sel_drop();
    test_random();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
